// File: rtl/apb_pkg.sv
// Shared types and constants for the APB register bank.
// The state enum and the ID value seen at the top register slot.
package apb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_state_e;

   localparam logic [31:0] ID_VALUE = 32'hA5B0_0001;

endpackage

// File: rtl/apb_regfile.sv
// Word register storage for the APB bank.
// The top slot is a read-only ID register.
module apb_regfile
   import apb_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_REGS   = 16,
   parameter int IDX_W      = $clog2(NUM_REGS)
) (
   input  logic                  PCLK,
   input  logic                  PRESETn,
   input  logic                  we,
   input  logic [IDX_W-1:0]      idx,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic [DATA_WIDTH-1:0] rdata
);

   localparam logic [IDX_W-1:0] ID_IDX = IDX_W'(NUM_REGS - 1);

   logic [DATA_WIDTH-1:0] mem_q [NUM_REGS];

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            mem_q[i] <= '0;
         end
      end else if (we && idx != ID_IDX) begin
         mem_q[idx] <= wdata;
      end
   end

   assign rdata = (idx == ID_IDX) ? DATA_WIDTH'(ID_VALUE)
                                  : mem_q[idx];

endmodule

// File: rtl/apb_slave_regbank.sv
// APB slave with a small register bank and programmable wait states.
// Outputs are decoded from flops only: state, counter, latched request.
module apb_slave_regbank
   import apb_pkg::*;
#(
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32,
   parameter int NUM_REGS    = 16,
   parameter int WAIT_STATES = 1
) (
   input  logic                  PCLK,
   input  logic                  PRESETn,
   input  logic                  PSEL,
   input  logic                  PENABLE,
   input  logic                  PWRITE,
   input  logic [ADDR_WIDTH-1:0] PADDR,
   input  logic [DATA_WIDTH-1:0] PWDATA,
   output logic [DATA_WIDTH-1:0] PRDATA,
   output logic                  PREADY,
   output logic                  PSLVERR
);

   localparam int IW = $clog2(NUM_REGS);
   localparam logic [IW-1:0] ID_IDX = IW'(NUM_REGS - 1);

   apb_state_e            state_q;
   apb_state_e            phase;
   logic [3:0]            cnt_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic                  write_q;
   logic [IW-1:0]         idx;
   logic                  err;
   logic                  ready;
   logic                  xfer_ok;
   logic                  we;
   logic [DATA_WIDTH-1:0] rdata;

   // A setup phase seen in IDLE is the SETUP cycle itself,
   // so a zero-wait transfer completes on its second bus cycle.
   always_comb begin
      phase = state_q;
      if (state_q == IDLE && PSEL && !PENABLE) begin
         phase = SETUP;
      end
   end

   assign idx     = addr_q[2 +: IW];
   assign err     = (addr_q[1:0] != 2'b00)
                 || ((addr_q >> (2 + IW)) != '0)
                 || (write_q && idx == ID_IDX);
   assign ready   = (state_q == ACCESS) && (cnt_q == 4'd0);
   assign xfer_ok = ready && PSEL && PENABLE;
   assign we      = xfer_ok && write_q && !err;

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         addr_q  <= '0;
         write_q <= 1'b0;
      end else begin
         case (phase)
            SETUP: begin
               state_q <= ACCESS;
               addr_q  <= PADDR;
               write_q <= PWRITE;
               cnt_q   <= 4'(WAIT_STATES);
            end
            ACCESS: begin
               if (!(PSEL && PENABLE)) begin
                  state_q <= IDLE;
                  cnt_q   <= 4'd0;
               end else if (cnt_q != 4'd0) begin
                  cnt_q <= cnt_q - 4'd1;
               end else begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   apb_regfile #(
      .DATA_WIDTH (DATA_WIDTH),
      .NUM_REGS   (NUM_REGS),
      .IDX_W      (IW)
   ) u_regfile (
      .PCLK    (PCLK),
      .PRESETn (PRESETn),
      .we      (we),
      .idx     (idx),
      .wdata   (PWDATA),
      .rdata   (rdata)
   );

   assign PREADY  = ready;
   assign PSLVERR = ready && err;
   assign PRDATA  = (ready && !write_q && !err) ? rdata : '0;

endmodule

// File: tb/tb_apb_slave_regbank.sv
// Bench for apb_slave_regbank: three instances with 1, 0 and 3 wait
// states share one bus and are checked against a register-array model.
module tb_apb_slave_regbank;

   localparam logic [31:0] ID = 32'hA5B0_0001;

   logic        clk = 1'b0;
   logic        PRESETn;
   logic [2:0]  psel;
   logic        PENABLE;
   logic        PWRITE;
   logic [31:0] PADDR;
   logic [31:0] PWDATA;
   logic [31:0] prdata [3];
   logic        pready [3];
   logic        pslverr [3];

   logic [31:0] model [3][16];
   int          ws [3] = '{1, 0, 3};
   int          vectors = 0;
   int          miscompares = 0;

   always #5 clk = ~clk;

   apb_slave_regbank #(.WAIT_STATES(1)) u_dut0 (
      .PCLK(clk), .PRESETn(PRESETn), .PSEL(psel[0]),
      .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
      .PWDATA(PWDATA), .PRDATA(prdata[0]), .PREADY(pready[0]),
      .PSLVERR(pslverr[0]));

   apb_slave_regbank #(.WAIT_STATES(0)) u_dut1 (
      .PCLK(clk), .PRESETn(PRESETn), .PSEL(psel[1]),
      .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
      .PWDATA(PWDATA), .PRDATA(prdata[1]), .PREADY(pready[1]),
      .PSLVERR(pslverr[1]));

   apb_slave_regbank #(.WAIT_STATES(3)) u_dut2 (
      .PCLK(clk), .PRESETn(PRESETn), .PSEL(psel[2]),
      .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
      .PWDATA(PWDATA), .PRDATA(prdata[2]), .PREADY(pready[2]),
      .PSLVERR(pslverr[2]));

   function automatic bit exp_err(bit wr, logic [31:0] a);
      return (a % 4 != 0) || (a >= 64) || (wr && a / 4 == 15);
   endfunction

   function automatic logic [31:0] exp_rd(int d, bit wr,
                                          logic [31:0] a);
      if (wr || exp_err(wr, a)) return 32'h0;
      if (a / 4 == 15) return ID;
      return model[d][a / 4];
   endfunction

   task automatic model_write(int d, bit wr, logic [31:0] a,
                              logic [31:0] v);
      if (wr && !exp_err(wr, a)) model[d][a / 4] = v;
   endtask

   task automatic clear_model();
      for (int d = 0; d < 3; d++)
         for (int i = 0; i < 16; i++) model[d][i] = 32'h0;
   endtask

   // Drives one transfer; returns what was observed on completion.
   task automatic xfer(input int d, input bit wr,
                       input logic [31:0] addr,
                       input logic [31:0] wdata, input bit scr,
                       output logic [31:0] rd, output logic er,
                       output int cyc, output bit quiet);
      bit done = 0;
      quiet = 1; cyc = 0; rd = '0; er = 0;
      psel[d] = 1; PENABLE = 0; PWRITE = wr;
      PADDR = addr; PWDATA = wdata;
      @(negedge clk); cyc = 1;
      if (pready[d] || pslverr[d] || prdata[d] != 0) quiet = 0;
      @(posedge clk); #1;
      PENABLE = 1;
      if (scr) begin
         PADDR = $urandom; PWRITE = 1'($urandom);
      end
      while (!done && cyc < 40) begin
         @(negedge clk); cyc++;
         if (pready[d]) begin
            rd = prdata[d]; er = pslverr[d]; done = 1;
         end else if (pslverr[d] || prdata[d] != 0) begin
            quiet = 0;
         end
         @(posedge clk); #1;
      end
      if (!done) cyc = -1;
      psel[d] = 0; PENABLE = 0;
   endtask

   task automatic do_reset();
      psel = '0; PENABLE = 0; PWRITE = 0;
      PADDR = '0; PWDATA = '0;
      PRESETn = 0;
      repeat (2) @(negedge clk);
      PRESETn = 1;
      clear_model();
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      logic [31:0] rd; logic er; int cyc; bit q;
      psel = '0; PENABLE = 0; PWRITE = 0;
      PADDR = '0; PWDATA = '0;
      PRESETn = 0;
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         vectors++;
         if ({pready[d], pslverr[d], prdata[d]} !== 34'h0) begin
            miscompares++;
            $display("FAIL reset_out dut%0d got %b/%b/%h want 0",
                     d, pready[d], pslverr[d], prdata[d]);
         end
      end
      PRESETn = 1;
      clear_model();
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) begin
         xfer(0, 0, 32'(i * 4), 0, 0, rd, er, cyc, q);
         vectors++;
         if (rd !== 32'h0 || er !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_reg idx%0d got %h/%b want 0/0",
                     i, rd, er);
         end
      end
   endtask

   task automatic test_basic();
      logic [31:0] rd; logic er; int cyc; bit q;
      xfer(0, 1, 32'h04, 32'hDEAD_BEEF, 0, rd, er, cyc, q);
      model_write(0, 1, 32'h04, 32'hDEAD_BEEF);
      vectors++;
      if (cyc !== 3 || er !== 1'b0 || q !== 1'b1) begin
         miscompares++;
         $display("FAIL basic_wr cyc=%0d err=%b quiet=%b want 3/0/1",
                  cyc, er, q);
      end
      xfer(0, 0, 32'h04, 0, 0, rd, er, cyc, q);
      vectors++;
      if (rd !== 32'hDEAD_BEEF || er !== 1'b0 || cyc !== 3) begin
         miscompares++;
         $display("FAIL basic_rd got %h/%b/%0d want deadbeef/0/3",
                  rd, er, cyc);
      end
   endtask

   task automatic test_id();
      logic [31:0] rd; logic er; int cyc; bit q;
      xfer(0, 0, 32'h3C, 0, 0, rd, er, cyc, q);
      vectors++;
      if (rd !== ID || er !== 1'b0) begin
         miscompares++;
         $display("FAIL id_rd got %h/%b want %h/0", rd, er, ID);
      end
      xfer(0, 1, 32'h3C, 32'h1234, 0, rd, er, cyc, q);
      vectors++;
      if (er !== 1'b1 || rd !== 32'h0) begin
         miscompares++;
         $display("FAIL id_wr err=%b rd=%h want 1/0", er, rd);
      end
      xfer(0, 0, 32'h3C, 0, 0, rd, er, cyc, q);
      vectors++;
      if (rd !== ID) begin
         miscompares++;
         $display("FAIL id_reread got %h want %h", rd, ID);
      end
   endtask

   task automatic test_errors();
      logic [31:0] rd; logic er; int cyc; bit q;
      logic [31:0] bad [2] = '{32'h06, 32'h40};
      for (int k = 0; k < 2; k++) begin
         xfer(0, 1, bad[k], 32'hFFFF_FFFF, 0, rd, er, cyc, q);
         vectors++;
         if (er !== 1'b1 || cyc !== 3 || q !== 1'b1) begin
            miscompares++;
            $display("FAIL err_wr a=%h err=%b cyc=%0d q=%b want 1/3/1",
                     bad[k], er, cyc, q);
         end
      end
      for (int i = 0; i < 15; i++) begin
         xfer(0, 0, 32'(i * 4), 0, 0, rd, er, cyc, q);
         vectors++;
         if (rd !== model[0][i]) begin
            miscompares++;
            $display("FAIL err_keep idx%0d got %h want %h",
                     i, rd, model[0][i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] rd; logic er; int c1; int c2; bit q;
      xfer(1, 1, 32'h08, 32'h11, 0, rd, er, c1, q);
      xfer(1, 1, 32'h0C, 32'h22, 0, rd, er, c2, q);
      model_write(1, 1, 32'h08, 32'h11);
      model_write(1, 1, 32'h0C, 32'h22);
      vectors++;
      if (c1 !== 2 || c2 !== 2) begin
         miscompares++;
         $display("FAIL b2b_cycles got %0d/%0d want 2/2", c1, c2);
      end
      xfer(1, 0, 32'h08, 0, 0, rd, er, c1, q);
      vectors++;
      if (rd !== 32'h11) begin
         miscompares++;
         $display("FAIL b2b_rd08 got %h want 11", rd);
      end
      xfer(1, 0, 32'h0C, 0, 0, rd, er, c1, q);
      vectors++;
      if (rd !== 32'h22) begin
         miscompares++;
         $display("FAIL b2b_rd0c got %h want 22", rd);
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] rd; logic er; int cyc; bit q;
      psel[0] = 1; PENABLE = 0; PWRITE = 1;
      PADDR = 32'h10; PWDATA = 32'h55;
      @(posedge clk); #1; PENABLE = 1;
      @(posedge clk); #3;
      vectors++;
      if (pready[0] !== 1'b1) begin
         miscompares++;
         $display("FAIL rstmid_pre pready=%b want 1", pready[0]);
      end
      PRESETn = 0;
      #1;
      vectors++;
      if ({pready[0], pslverr[0], prdata[0]} !== 34'h0) begin
         miscompares++;
         $display("FAIL rstmid_async got %b/%b/%h want 0",
                  pready[0], pslverr[0], prdata[0]);
      end
      @(posedge clk); #1;
      psel = '0; PENABLE = 0;
      @(negedge clk);
      PRESETn = 1;
      clear_model();
      @(posedge clk); #1;
      xfer(0, 0, 32'h10, 0, 0, rd, er, cyc, q);
      vectors++;
      if (rd !== 32'h0 || cyc !== 3) begin
         miscompares++;
         $display("FAIL rstmid_rd got %h/%0d want 0/3", rd, cyc);
      end
   endtask

   task automatic test_abort();
      logic [31:0] rd; logic er; int cyc; bit q;
      bit seen = 0;
      xfer(2, 1, 32'h20, 32'h33, 0, rd, er, cyc, q);
      model_write(2, 1, 32'h20, 32'h33);
      psel[2] = 1; PENABLE = 0; PWRITE = 1;
      PADDR = 32'h20; PWDATA = 32'h77;
      @(negedge clk); if (pready[2]) seen = 1;
      @(posedge clk); #1; PENABLE = 1;
      repeat (2) begin
         @(negedge clk); if (pready[2]) seen = 1;
         @(posedge clk); #1;
      end
      PENABLE = 0;
      @(negedge clk); if (pready[2]) seen = 1;
      @(posedge clk); #1; psel[2] = 0;
      repeat (4) begin
         @(negedge clk); if (pready[2]) seen = 1;
      end
      @(posedge clk); #1;
      vectors++;
      if (seen !== 1'b0) begin
         miscompares++;
         $display("FAIL abort_ready pready seen=%b want 0", seen);
      end
      xfer(2, 0, 32'h20, 0, 0, rd, er, cyc, q);
      vectors++;
      if (rd !== model[2][8]) begin
         miscompares++;
         $display("FAIL abort_keep got %h want %h", rd, model[2][8]);
      end
      xfer(2, 1, 32'h20, 32'h99, 0, rd, er, cyc, q);
      model_write(2, 1, 32'h20, 32'h99);
      vectors++;
      if (cyc !== 5 || er !== 1'b0) begin
         miscompares++;
         $display("FAIL abort_next cyc=%0d err=%b want 5/0", cyc, er);
      end
      xfer(2, 0, 32'h20, 0, 0, rd, er, cyc, q);
      vectors++;
      if (rd !== 32'h99) begin
         miscompares++;
         $display("FAIL abort_rd got %h want 99", rd);
      end
   endtask

   task automatic test_idle_penable();
      logic [31:0] rd; logic er; int cyc; bit q;
      bit seen = 0;
      psel[0] = 1; PENABLE = 1; PWRITE = 1;
      PADDR = 32'h00; PWDATA = 32'hFFFF;
      repeat (4) begin
         @(negedge clk); if (pready[0]) seen = 1;
      end
      @(posedge clk); #1;
      psel[0] = 0; PENABLE = 0;
      vectors++;
      if (seen !== 1'b0) begin
         miscompares++;
         $display("FAIL idle_pen pready seen=%b want 0", seen);
      end
      xfer(0, 0, 32'h00, 0, 0, rd, er, cyc, q);
      vectors++;
      if (rd !== model[0][0]) begin
         miscompares++;
         $display("FAIL idle_pen_rd got %h want %h", rd, model[0][0]);
      end
   endtask

   task automatic test_random();
      logic [31:0] rd; logic er; int cyc; bit q;
      logic [31:0] a; logic [31:0] wd; bit wr; bit scr; int d;
      int kind;
      for (int n = 0; n < 80; n++) begin
         d = $urandom_range(0, 2);
         kind = $urandom_range(0, 7);
         wr = 1'($urandom);
         scr = 1'($urandom);
         wd = $urandom;
         if (kind < 6) a = 32'($urandom_range(0, 15) * 4);
         else if (kind == 6) a = 32'($urandom_range(0, 63)) | 32'h1;
         else a = 32'h40 + (($urandom % 32'h3FFF_FFF0) & ~32'h3);
         xfer(d, wr, a, wd, scr, rd, er, cyc, q);
         vectors++;
         if (rd !== exp_rd(d, wr, a) || er !== exp_err(wr, a)) begin
            miscompares++;
            $display("FAIL rnd%0d dut%0d a=%h wr=%b got %h/%b want %h/%b",
                     n, d, a, wr, rd, er, exp_rd(d, wr, a),
                     exp_err(wr, a));
         end
         vectors++;
         if (cyc !== 2 + ws[d] || q !== 1'b1) begin
            miscompares++;
            $display("FAIL rnd%0d_timing dut%0d cyc=%0d q=%b want %0d/1",
                     n, d, cyc, q, 2 + ws[d]);
         end
         model_write(d, wr, a, wd);
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
         end
      end
   endtask

   initial begin
      do_reset();
      test_reset();
      test_basic();
      test_id();
      test_errors();
      test_back_to_back();
      test_idle_penable();
      test_abort();
      test_random();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
